// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the MIPS opcodes that steer control flow, and the default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// npc_calc
// Combinational next-PC selection for the issued instruction.
// Ports:
//   i_pc          address of the issued instruction
//   i_instr       issued instruction word (imm16 / target26 fields)
//   i_branch      BEQ:  taken when i_alu_zero
//   i_branch_ne   BNE:  taken when !i_alu_zero
//   i_branch_gz   BGTZ: taken when i_rs_gtz
//   i_jump        J/JAL: overrides every branch flag
//   i_alu_zero    rs == rt
//   i_rs_gtz      rs > 0 (signed)
//   o_pc_plus4    i_pc + 4, wrapping modulo 2^32
//   o_next_pc     address of the next instruction to fetch
module npc_calc (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_branch,
    input  logic        i_branch_ne,
    input  logic        i_branch_gz,
    input  logic        i_jump,
    input  logic        i_alu_zero,
    input  logic        i_rs_gtz,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic        w_taken;

    assign w_pc_plus4    = i_pc + 32'd4;
    // imm16 sign-extended and scaled to a byte offset in one concatenation.
    assign w_br_offset   = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign w_br_target   = w_pc_plus4 + w_br_offset;
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign w_jump_target = {w_pc_plus4[31:28], i_instr[25:0], 2'b00};

    assign w_taken = (i_branch    &  i_alu_zero) |
                     (i_branch_ne & ~i_alu_zero) |
                     (i_branch_gz &  i_rs_gtz);

    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (w_taken) begin
            o_next_pc = w_br_target;
        end
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Fetches one instruction at a time from instruction memory, holds it for
// the downstream stage, then selects the next PC from the decoder controls.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/imem_addr    read request; address stable while imem_req=1
//   imem_ack/imem_rdata   one-cycle acknowledge carrying the instruction word
//   stall                 downstream not ready; issued instruction is held
//   branch, branch_ne,
//   branch_gz, jump       decoder control flow flags for the issued instruction
//   alu_zero, rs_gtz      comparison results for the issued instruction
//   instr/opcode/funct/pc issued instruction, its fields and its address
//   pc_plus4              pc + 4
//   instr_valid           issued outputs are meaningful
//   fsm_state             current FSM state (fetch_state_e encoding)
//
// Memory handshake: a request is open while imem_req=1 and closes in the
// cycle imem_ack=1 is seen in FETCH; imem_rdata is taken only in that cycle.
// Acks arriving while no request is open are ignored.
// Issue handshake: instr_valid=1 offers the instruction; it is consumed in
// the first cycle with instr_valid=1 and stall=0, and the control inputs are
// sampled in that same cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        branch_gz,
    input  logic        jump,
    input  logic        alu_zero,
    input  logic        rs_gtz,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [1:0]  fsm_state
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_fetch_pc;
    logic         r_req;
    logic         r_valid;

    logic [31:0]  w_next_pc;
    logic [31:0]  w_pc_plus4;

    npc_calc u_npc_calc (
        .i_pc        (r_pc),
        .i_instr     (r_instr),
        .i_branch    (branch),
        .i_branch_ne (branch_ne),
        .i_branch_gz (branch_gz),
        .i_jump      (jump),
        .i_alu_zero  (alu_zero),
        .i_rs_gtz    (rs_gtz),
        .o_pc_plus4  (w_pc_plus4),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC_ALIGNED;
            r_instr    <= 32'd0;
            r_fetch_pc <= RESET_PC_ALIGNED;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // r_fetch_pc already holds the reset PC.
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_fetch_pc;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        r_fetch_pc <= w_next_pc;
                        r_req      <= 1'b1;
                        r_valid    <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_fetch_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr_valid = r_valid;
    assign fsm_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Randomized bench for fetch_unit: a memory responder and a control driver
// produce stimulus, a reference model predicts the fetch address sequence,
// and a monitor compares every request and every issued instruction.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NDIR = 9;
    // Directed prologue: {jump, branch, branch_ne, branch_gz, alu_zero, rs_gtz}
    localparam logic [5:0] DIR_CTL [0:NDIR-1] = '{
        6'b000000, 6'b000000, 6'b010010, 6'b010010, 6'b001010,
        6'b100000, 6'b110010, 6'b000101, 6'b000000};
    localparam int DIR_STALL [0:NDIR-1] = '{0, 0, 0, 0, 5, 0, 0, 0, 0};
    localparam logic [31:0] DIR_ADDR [0:9] = '{
        32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_0100,
        32'h0000_0100, 32'h0000_0104, 32'h0040_0000, 32'h0000_0040,
        32'hFFFF_FFFC, 32'h0000_0000};

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch, branch_ne, branch_gz, jump, alu_zero, rs_gtz;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall),
        .branch(branch), .branch_ne(branch_ne), .branch_gz(branch_gz),
        .jump(jump), .alu_zero(alu_zero), .rs_gtz(rs_gtz),
        .instr(instr), .opcode(opcode), .funct(funct),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .fsm_state(fsm_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic mem_block = 1'b0;
    logic spur_force = 1'b0;
    logic rand_phase = 1'b0;
    int mon_issue = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                                input logic j, input logic b, input logic bne,
                                                input logic bgz, input logic az, input logic gtz);
        logic [31:0] seq;
        logic signed [15:0] imm;
        int off;
        logic [31:0] off_u;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        imm = ins[15:0];
        off = imm * 4;
        off_u = off;
        if ((b && az) || (bne && !az) || (bgz && gtz)) return seq + off_u;
        return seq;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    initial begin : mem_drv
        logic pend;
        int dly;
        pend = 1'b0;
        dly = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        mem[32'h0000_0008] = {OP_BEQ, 10'd0, 16'h003D};
        mem[32'h0000_0100] = {OP_BEQ, 10'd0, 16'hFFFF};
        mem[32'h0000_0104] = {OP_J, 26'h010_0000};
        mem[32'h0040_0000] = {OP_JAL, 26'h000_0010};
        mem[32'h0000_0040] = {OP_BGTZ, 10'd0, 16'hFFEE};
        forever begin
            @(posedge clk);
            #1;
            if (!imem_req && spur_force) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_ack) begin
                imem_ack = 1'b0;
            end else if (!imem_req) begin
                pend = 1'b0;
                if (rand_phase && $urandom_range(0, 7) == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = $urandom;
                end
            end else if (!mem_block) begin
                if (!pend) begin
                    pend = 1'b1;
                    dly = rand_phase ? $urandom_range(0, 2) : 0;
                end else if (dly > 0) begin
                    dly--;
                end else begin
                    pend = 1'b0;
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end
            end
        end
    end

    // ---------------- control / stall driver ----------------
    initial begin : ctl_drv
        int idx;
        int stall_left;
        logic pv;
        logic [5:0] cur_ctl;
        idx = -1;
        stall_left = 0;
        pv = 1'b0;
        cur_ctl = 6'd0;
        {jump, branch, branch_ne, branch_gz, alu_zero, rs_gtz} = 6'd0;
        stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (instr_valid && !pv) begin
                idx++;
                if (!rand_phase && idx < NDIR) begin
                    cur_ctl = DIR_CTL[idx];
                    stall_left = DIR_STALL[idx];
                end else begin
                    rand_phase = 1'b1;
                    stall_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                end
            end
            if (rand_phase) begin
                jump = ($urandom_range(0, 5) == 0);
                branch = 1'($urandom_range(0, 1));
                branch_ne = 1'($urandom_range(0, 1));
                branch_gz = 1'($urandom_range(0, 1));
                alu_zero = 1'($urandom_range(0, 1));
                rs_gtz = 1'($urandom_range(0, 1));
            end else begin
                {jump, branch, branch_ne, branch_gz, alu_zero, rs_gtz} = instr_valid ? cur_ctl : 6'd0;
            end
            if (instr_valid) begin
                stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end else begin
                stall = rand_phase ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pv = instr_valid;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];

    initial begin : monitor
        logic [31:0] cur_pc;
        logic [31:0] cur_ins;
        logic prev_valid;
        logic prev_stall;
        int last_issue_cyc;
        int acc_cnt;
        cur_pc = 32'd0;
        cur_ins = 32'd0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        last_issue_cyc = 0;
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                // Every reset restarts fetching at the reset PC.
                exp_addr_q.delete();
                exp_addr_q.push_back(RST_PC);
                exp_pc_q.delete();
                exp_ins_q.delete();
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (imem_req) begin
                    check32("valid_during_req", {31'd0, instr_valid}, 32'd0);
                    if (exp_addr_q.size() == 0) begin
                        fail_now("unexpected_req");
                    end else begin
                        check32("imem_addr", imem_addr, exp_addr_q[0]);
                        if (imem_ack) begin
                            if (acc_cnt < 10) check32("directed_addr", imem_addr, DIR_ADDR[acc_cnt]);
                            acc_cnt++;
                            exp_pc_q.push_back(exp_addr_q.pop_front());
                            exp_ins_q.push_back(imem_rdata);
                        end
                    end
                end
                if (instr_valid) begin
                    check32("req_in_issue", {31'd0, imem_req}, 32'd0);
                    if (!prev_valid) begin
                        if (exp_pc_q.size() == 0) begin
                            fail_now("unexpected_issue");
                        end else begin
                            cur_pc = exp_pc_q.pop_front();
                            cur_ins = exp_ins_q.pop_front();
                        end
                        if (mon_issue >= 1 && mon_issue <= 3)
                            check32("issue_gap", cyc - last_issue_cyc, 32'd3);
                        last_issue_cyc = cyc;
                        mon_issue++;
                    end
                    check32("instr", instr, cur_ins);
                    check32("pc", pc, cur_pc);
                    check32("pc_plus4", pc_plus4, cur_pc + 32'd4);
                    check32("opcode", {26'd0, opcode}, cur_ins >> 26);
                    check32("funct", {26'd0, funct}, cur_ins & 32'h3F);
                    if (!stall)
                        exp_addr_q.push_back(ref_next_pc(cur_pc, cur_ins, jump, branch, branch_ne,
                                                         branch_gz, alu_zero, rs_gtz));
                end
                if (prev_valid) begin
                    if (prev_stall) check32("stall_hold", {30'd0, instr_valid, imem_req}, 32'd2);
                    else            check32("resume_fetch", {30'd0, instr_valid, imem_req}, 32'd1);
                end
                prev_valid = instr_valid;
                prev_stall = stall;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        repeat (50000) @(posedge clk);
        fail_now("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int target;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check32("rst_pc", pc, RST_PC);
        check32("rst_instr", instr, 32'd0);
        check32("rst_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_addr", imem_addr, RST_PC);
        check32("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        check32("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        check32("idle_to_fetch", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 6000 && mon_issue < 80; i++) @(posedge clk);
        if (mon_issue < 80) fail_now("timeout_run1");

        // Reset while a request is outstanding and memory is holding its ack.
        mem_block = 1'b1;
        for (int i = 0; i < 200 && !imem_req; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (!imem_req) fail_now("no_req_before_reset");
        mon_en = 1'b0;
        spur_force = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check32("rst_abort_req", {31'd0, imem_req}, 32'd0);
        check32("rst_abort_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_abort_pc", pc, RST_PC);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        check32("post_rst_req", {31'd0, imem_req}, 32'd1);
        check32("post_rst_addr", imem_addr, RST_PC);
        check32("post_rst_instr", instr, 32'd0);
        spur_force = 1'b0;
        mem_block = 1'b0;

        target = mon_issue + 40;
        for (int i = 0; i < 4000 && mon_issue < target; i++) @(posedge clk);
        if (mon_issue < target) fail_now("timeout_run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
